sevenseg_frame_decoder: RTL

- Receive-side counterpart of the datapath blocks that drive multiplexed 7-segment digits: converts scanned segment patterns back into binary nibbles.
- Debounces each digit's pattern and flags illegal glyphs.
- Assembles a complete multi-digit frame and presents it on a valid/ready output.
- Sits between a segment-scan capture interface and downstream check/compare logic.

---
 rtl/sevenseg_frame_decoder_if.sv | 49 ++++
 rtl/sevenseg_frame_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sevenseg_frame_decoder_if.sv
// Segment-scan capture bus for sevenseg_frame_decoder.
// The master drives the scanned pattern, the digit select and the downstream ready.
// The slave (the decoder) returns the assembled frame, the error pulses and busy.
//   seg_in    : segment pattern {g,f,e,d,c,b,a}, active high
//   dig_sel   : one-hot digit select, bit i selects slot i
//   in_valid  : seg_in/dig_sel are meaningful this cycle
//   out_data  : frame, slot i at out_data[4i+3:4i]
//   out_valid : frame complete and held
//   out_ready : downstream accepts the frame
//   err_glyph : one-cycle pulse, a stable pattern is not a legal hex glyph
//   err_sel   : one-cycle pulse, in_valid with a dig_sel that is not one-hot
//   busy      : tracking a pattern, holding a partial frame, or presenting a frame
interface sevenseg_frame_decoder_if #(
  parameter int unsigned DIGITS = 2
) ();
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic                in_valid;
  logic [4*DIGITS-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic                err_glyph;
  logic                err_sel;
  logic                busy;

  modport master (
    output seg_in,
    output dig_sel,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  err_glyph,
    input  err_sel,
    input  busy
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output err_glyph,
    output err_sel,
    output busy
  );
endinterface

// File: rtl/sevenseg_frame_decoder.sv
// Converts scanned multiplexed 7-segment patterns back into hex nibbles.
// Each digit's pattern must be seen unchanged for STABLE_CYC consecutive valid cycles
// before it is accepted; accepted legal glyphs fill their slot, and once every slot
// is filled the frame is presented on out_data/out_valid until out_ready.
// Ports:
//   CK  : clock, rising edge
//   RN  : synchronous active-low reset
//   bus : slave side of sevenseg_frame_decoder_if (scan input, frame output, flags)
module sevenseg_frame_decoder #(
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned STABLE_CYC = 3
) (
  input logic                     CK,
  input logic                     RN,
  sevenseg_frame_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);

  typedef enum logic [0:0] {StCollect, StOut} state_e;

  state_e              r_state;
  logic [6:0]          r_last_seg;
  logic [DIGITS-1:0]   r_last_sel;
  logic [CntW-1:0]     r_cnt;
  logic                r_taken;
  logic [DIGITS-1:0]   r_flags;
  logic [4*DIGITS-1:0] r_data;
  logic                r_out_valid;
  logic                r_err_glyph;
  logic                r_err_sel;

  logic                w_blank;
  logic                w_sel_onehot;
  logic                w_same;
  logic [CntW-1:0]     w_cnt_inc;
  logic                w_accept;
  logic                w_legal;
  logic [3:0]          w_nibble;
  logic [DIGITS-1:0]   w_flags_nxt;
  logic [4*DIGITS-1:0] w_data_nxt;

  assign w_blank      = (bus.seg_in == 7'h00);
  assign w_sel_onehot = (bus.dig_sel != '0) && ((bus.dig_sel & (bus.dig_sel - 1'b1)) == '0);
  assign w_same       = (bus.seg_in == r_last_seg) && (bus.dig_sel == r_last_sel);
  assign w_cnt_inc    = (r_cnt == CntMax) ? r_cnt : r_cnt + 1'b1;

  // Accept only on the cycle the run first reaches STABLE_CYC; taken blocks re-acceptance
  // while the same run keeps going.
  assign w_accept = (r_state == StCollect) && bus.in_valid && !w_blank && w_sel_onehot &&
                    w_same && !r_taken && (w_cnt_inc == CntMax);

  always_comb begin
    w_legal  = 1'b1;
    w_nibble = 4'h0;
    unique case (bus.seg_in)
      7'h3F: w_nibble = 4'h0;
      7'h06: w_nibble = 4'h1;
      7'h5B: w_nibble = 4'h2;
      7'h4F: w_nibble = 4'h3;
      7'h66: w_nibble = 4'h4;
      7'h6D: w_nibble = 4'h5;
      7'h7D: w_nibble = 4'h6;
      7'h07: w_nibble = 4'h7;
      7'h7F: w_nibble = 4'h8;
      7'h6F: w_nibble = 4'h9;
      7'h77: w_nibble = 4'hA;
      7'h7C: w_nibble = 4'hB;
      7'h39: w_nibble = 4'hC;
      7'h5E: w_nibble = 4'hD;
      7'h79: w_nibble = 4'hE;
      7'h71: w_nibble = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // Slot update for an accepted pattern: legal writes (latest wins), illegal clears.
  always_comb begin
    w_flags_nxt = r_flags;
    w_data_nxt  = r_data;
    if (w_accept) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (bus.dig_sel[i]) begin
          w_flags_nxt[i]       = w_legal;
          w_data_nxt[4*i +: 4] = w_legal ? w_nibble : 4'h0;
        end
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      r_state     <= StCollect;
      r_last_seg  <= '0;
      r_last_sel  <= '0;
      r_cnt       <= '0;
      r_taken     <= 1'b0;
      r_flags     <= '0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      r_err_glyph <= 1'b0;
      r_err_sel   <= 1'b0;
    end else begin
      r_err_glyph <= 1'b0;
      r_err_sel   <= 1'b0;
      unique case (r_state)
        StCollect: begin
          if (!bus.in_valid || w_blank) begin
            r_cnt   <= '0;
            r_taken <= 1'b0;
          end else if (!w_sel_onehot) begin
            r_err_sel <= 1'b1;
            r_cnt     <= '0;
            r_taken   <= 1'b0;
          end else if (!w_same) begin
            r_last_seg <= bus.seg_in;
            r_last_sel <= bus.dig_sel;
            r_cnt      <= CntW'(1);
            r_taken    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_accept) begin
              r_taken     <= 1'b1;
              r_err_glyph <= !w_legal;
            end
          end
          r_flags <= w_flags_nxt;
          r_data  <= w_data_nxt;
          // Frame completes on the same edge the last nibble lands; the tracker is
          // cleared here so OUT starts with it already idle.
          if (&w_flags_nxt) begin
            r_state     <= StOut;
            r_out_valid <= 1'b1;
            r_last_seg  <= '0;
            r_last_sel  <= '0;
            r_cnt       <= '0;
            r_taken     <= 1'b0;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            r_state     <= StCollect;
            r_out_valid <= 1'b0;
            r_flags     <= '0;
            r_data      <= '0;
          end
        end
        default: r_state <= StCollect;
      endcase
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_out_valid;
  assign bus.err_glyph = r_err_glyph;
  assign bus.err_sel   = r_err_sel;
  assign bus.busy      = (r_cnt != '0) || (|r_flags) || (r_state == StOut);

endmodule
